// File: rtl/rx_sample_fifo.sv
// Elastic sample buffer feeding a valid/ready stream from a source that cannot be stalled.
// Optional RX_SAMPLE_FIFO_HWM_EN adds an o_hwm occupancy high-water-mark output.
module rx_sample_fifo #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AFULL_LVL = 12
) (
  input  logic                       clk,
  input  logic                       srst_n,
  input  logic                       i_enable,
  input  logic [DATA_W-1:0]          i_data,
  input  logic                       i_valid,
  output logic [DATA_W-1:0]          o_data,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_almost_full,
  output logic                       o_overflow,
  input  logic                       i_overflow_clear,
  output logic [15:0]                o_drop_count
`ifdef RX_SAMPLE_FIFO_HWM_EN
  ,
  output logic [$clog2(DEPTH):0]     o_hwm
`endif
);

  localparam int unsigned CW    = $clog2(DEPTH) + 1;
  localparam int unsigned RAM_D = DEPTH - 1;
  localparam int unsigned PW    = $clog2(DEPTH);

  // Circular storage behind the output register; pointers wrap modulo RAM_D.
  logic [DATA_W-1:0] mem_q [RAM_D];

  logic [PW-1:0]     rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              afull_q, afull_d;
  logic              ovf_q, ovf_d;
  logic [15:0]       drop_q, drop_d;

  logic              push_c, pop_c, full_c, accept_c, drop_c;
  logic              ram_empty_c, out_load_c, wr_en_c;
  logic [CW-1:0]     ram_cnt_c;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(RAM_D - 1)) ? '0 : p + PW'(1);
  endfunction

  // Handshake decode, output-stage refill, pointer and occupancy update.
  always_comb begin
    push_c      = i_enable & i_valid;
    pop_c       = out_valid_q & i_ready;
    full_c      = (count_q == CW'(DEPTH));
    accept_c    = push_c & (~full_c | pop_c);
    drop_c      = push_c & ~accept_c;
    ram_cnt_c   = count_q - CW'(out_valid_q);
    ram_empty_c = (ram_cnt_c == '0);
    out_load_c  = pop_c | ~out_valid_q;

    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    wr_en_c     = 1'b0;

    if (out_load_c) begin
      if (!ram_empty_c) begin
        out_data_d  = mem_q[rd_q];
        out_valid_d = 1'b1;
        rd_d        = ptr_next(rd_q);
      end else if (accept_c) begin
        out_data_d  = i_data;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end

    // A sample bypasses storage only when it goes straight into an empty output stage.
    if (accept_c && !(out_load_c && ram_empty_c)) begin
      wr_en_c = 1'b1;
      wr_d    = ptr_next(wr_q);
    end

    count_d = count_q;
    if (accept_c && !pop_c)      count_d = count_q + CW'(1);
    else if (pop_c && !accept_c) count_d = count_q - CW'(1);

    afull_d = (count_d >= CW'(AFULL_LVL));

    ovf_d  = ovf_q;
    drop_d = drop_q;
    if (drop_c) begin
      ovf_d  = 1'b1;
      drop_d = i_overflow_clear ? 16'd1 :
               (drop_q == 16'hFFFF) ? drop_q : drop_q + 16'd1;
    end else if (i_overflow_clear) begin
      ovf_d  = 1'b0;
      drop_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!srst_n) begin
      rd_q        <= '0;
      wr_q        <= '0;
      count_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      afull_q     <= 1'b0;
      ovf_q       <= 1'b0;
      drop_q      <= '0;
    end else begin
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      count_q     <= count_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      afull_q     <= afull_d;
      ovf_q       <= ovf_d;
      drop_q      <= drop_d;
    end
  end

  // Storage needs no reset: the pointers and occupancy define what is live.
  always_ff @(posedge clk) begin
    if (wr_en_c) mem_q[wr_q] <= i_data;
  end

  assign o_data        = out_data_q;
  assign o_valid       = out_valid_q;
  assign o_count       = count_q;
  assign o_almost_full = afull_q;
  assign o_overflow    = ovf_q;
  assign o_drop_count  = drop_q;

`ifdef RX_SAMPLE_FIFO_HWM_EN
  logic [CW-1:0] hwm_q, hwm_d;

  // A clear restarts tracking from the present occupancy.
  always_comb begin
    hwm_d = hwm_q;
    if (i_overflow_clear)      hwm_d = count_q;
    else if (count_d > hwm_q)  hwm_d = count_d;
  end

  always_ff @(posedge clk) begin
    if (!srst_n) hwm_q <= '0;
    else         hwm_q <= hwm_d;
  end

  assign o_hwm = hwm_q;
`endif

endmodule

// File: tb/tb_rx_sample_fifo.sv
// Directed self-checking bench for rx_sample_fifo (default parameters).
module tb_rx_sample_fifo;

  logic        clk = 1'b0;
  logic        srst_n;
  logic        i_enable;
  logic [31:0] i_data;
  logic        i_valid;
  logic [31:0] o_data;
  logic        o_valid;
  logic        i_ready;
  logic [4:0]  o_count;
  logic        o_almost_full;
  logic        o_overflow;
  logic        i_overflow_clear;
  logic [15:0] o_drop_count;
`ifdef RX_SAMPLE_FIFO_HWM_EN
  logic [4:0]  o_hwm;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  rx_sample_fifo dut (
    .clk              (clk),
    .srst_n           (srst_n),
    .i_enable         (i_enable),
    .i_data           (i_data),
    .i_valid          (i_valid),
    .o_data           (o_data),
    .o_valid          (o_valid),
    .i_ready          (i_ready),
    .o_count          (o_count),
    .o_almost_full    (o_almost_full),
    .o_overflow       (o_overflow),
    .i_overflow_clear (i_overflow_clear),
    .o_drop_count     (o_drop_count)
`ifdef RX_SAMPLE_FIFO_HWM_EN
    ,
    .o_hwm            (o_hwm)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_assert++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Inputs change 1 time unit after the edge; outputs are sampled at the same point.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    srst_n = 1'b0; i_enable = 1'b1; i_data = '0; i_valid = 1'b0;
    i_ready = 1'b0; i_overflow_clear = 1'b0;
    cycle(); cycle();
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_data",  o_data, 32'd0);
    check("rst_count", 32'(o_count), 32'd0);
    check("rst_afull", 32'(o_almost_full), 32'd0);
    check("rst_ovf",   32'(o_overflow), 32'd0);
    check("rst_drop",  32'(o_drop_count), 32'd0);
    srst_n = 1'b1;

    // Pass-through: each sample appears one cycle after its push
    i_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      i_data = 32'(k); i_valid = 1'b1;
      cycle();
      check("pt_valid", 32'(o_valid), 32'd1);
      check("pt_data",  o_data, 32'(k));
      check("pt_count", 32'(o_count), 32'd1);
    end
    i_valid = 1'b0;
    cycle();
    check("pt_empty_valid", 32'(o_valid), 32'd0);
    check("pt_empty_count", 32'(o_count), 32'd0);
    check("pt_ovf",         32'(o_overflow), 32'd0);

    // Fill and hold
    i_ready = 1'b0;
    for (int k = 0; k < 16; k++) begin
      i_data = 32'hA0 + 32'(k); i_valid = 1'b1;
      cycle();
      check("fill_count", 32'(o_count), 32'(k + 1));
      check("fill_afull", 32'(o_almost_full), (k + 1 >= 12) ? 32'd1 : 32'd0);
      check("fill_data",  o_data, 32'hA0);
      check("fill_valid", 32'(o_valid), 32'd1);
    end

    // Overflow: three drops at full
    for (int k = 0; k < 3; k++) begin
      i_data = 32'hEE + 32'(k);
      cycle();
      check("ovf_count", 32'(o_count), 32'd16);
      check("ovf_flag",  32'(o_overflow), 32'd1);
      check("ovf_drops", 32'(o_drop_count), 32'(k + 1));
      check("ovf_data",  o_data, 32'hA0);
    end

    // Full with simultaneous pop
    i_ready = 1'b1; i_data = 32'hB0;
    cycle();
    check("fp_count", 32'(o_count), 32'd16);
    check("fp_drops", 32'(o_drop_count), 32'd3);
    check("fp_data",  o_data, 32'hA1);

    // Drain: A1..AF then B0, with storage wrapped
    i_valid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      check("drain_valid", 32'(o_valid), 32'd1);
      check("drain_data",  o_data, (k < 15) ? 32'hA1 + 32'(k) : 32'hB0);
      cycle();
    end
    check("drain_empty", 32'(o_valid), 32'd0);
    check("drain_count", 32'(o_count), 32'd0);

    // Refill, then drop in the same cycle as a clear
    i_ready = 1'b0; i_valid = 1'b1;
    for (int k = 0; k < 16; k++) begin
      i_data = 32'hD0 + 32'(k);
      cycle();
    end
    check("refill_count", 32'(o_count), 32'd16);
    i_data = 32'hFF; i_overflow_clear = 1'b1;
    cycle();
    i_overflow_clear = 1'b0;
    check("race_ovf",  32'(o_overflow), 32'd1);
    check("race_drop", 32'(o_drop_count), 32'd1);

    // Saturation
    for (int k = 0; k < 70000; k++) cycle();
    check("sat_drop",  32'(o_drop_count), 32'hFFFF);
    check("sat_ovf",   32'(o_overflow), 32'd1);
    check("sat_count", 32'(o_count), 32'd16);
    check("sat_data",  o_data, 32'hD0);

    // Plain clear
    i_valid = 1'b0; i_overflow_clear = 1'b1;
    cycle();
    i_overflow_clear = 1'b0;
    check("clr_ovf",  32'(o_overflow), 32'd0);
    check("clr_drop", 32'(o_drop_count), 32'd0);

    // Disabled capture: no drop counted, drain continues
    i_enable = 1'b0; i_valid = 1'b1;
    cycle();
    check("dis_drop",  32'(o_drop_count), 32'd0);
    check("dis_count", 32'(o_count), 32'd16);
    i_ready = 1'b1;
    cycle();
    check("dis_pop_count", 32'(o_count), 32'd15);
    check("dis_pop_data",  o_data, 32'hD1);
    for (int k = 0; k < 6; k++) cycle();
    check("pre_rst_count", 32'(o_count), 32'd9);
    check("pre_rst_valid", 32'(o_valid), 32'd1);
    check("pre_rst_data",  o_data, 32'hD7);

    // Reset mid-operation
    srst_n = 1'b0; i_ready = 1'b0; i_valid = 1'b0; i_enable = 1'b1;
    cycle();
    srst_n = 1'b1;
    check("mrst_valid", 32'(o_valid), 32'd0);
    check("mrst_count", 32'(o_count), 32'd0);
    check("mrst_data",  o_data, 32'd0);
    i_data = 32'hC0; i_valid = 1'b1;
    cycle();
    i_data = 32'hC1;
    cycle();
    i_valid = 1'b0;
    check("post_rst_first", o_data, 32'hC0);
    check("post_rst_count", 32'(o_count), 32'd2);
    i_ready = 1'b1;
    cycle();
    check("post_rst_second", o_data, 32'hC1);
    cycle();
    check("post_rst_empty", 32'(o_valid), 32'd0);
`ifdef RX_SAMPLE_FIFO_HWM_EN
    check("hwm_after_rst", 32'(o_hwm), 32'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
